alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Result stage directly downstream of the 8-bit ALU.
- Accepts each 9-bit ALU result with its opcode and derives carry/zero/negative flags.
- Optionally commits the result into the architectural accumulator.
- Buffers result+flags in a small FIFO toward the consumer (register write port / debug bus) with valid/ready flow control.

Parameters:
DATA_W, 8, datapath width; ALU result is DATA_W+1 bits
DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  stage can accept; = !full
in_op  input  2  opcode that produced the result: 00 add, 01 sub, 10 and, 11 or
in_result  input  DATA_W+1  raw ALU output; bit DATA_W is carry/borrow
in_acc_we  input  1  commit result to accumulator on accept
acc_clr  input  1  clear accumulator and flags
acc  output  DATA_W  accumulator value
flag_c  output  1  sticky carry flag
flag_z  output  1  sticky zero flag
flag_n  output  1  sticky negative flag
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  DATA_W  head result
out_flags  output  3  head flags {c,z,n}
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low at edge): acc=0, flag_c/z/n=0, FIFO emptied, count=0, out_valid=0, out_data=0, out_flags=0; in_ready=1 once rst_n high. Reset mid-stream discards all buffered entries.
- Accept: in_valid && in_ready at edge. While in_ready=0, in_valid is ignored; the ALU holds its inputs.
- Flag derivation (combinational from inputs):
  - c = in_result[DATA_W] for op 00 (carry) and 01 (borrow, set when in_a < in_b); c = 0 for 10/11.
  - z = (in_result[DATA_W-1:0] == 0).
  - n = in_result[DATA_W-1].
- On accept:
  - Push {result[DATA_W-1:0], c, z, n} into FIFO.
  - If in_acc_we: acc <= result low bits, flags <= derived flags, visible the cycle after the edge.
  - If !in_acc_we: acc and flags unchanged.
- acc_clr: acc and flags <= 0 at edge.
  - Priority over a same-cycle accept with in_acc_we; that result is still pushed to the FIFO.
- FIFO:
  - Registered with circular read/write pointers; wraps DEPTH-1 -> 0.
  - Latency 1: entry accepted at edge N appears at head (out_valid=1) after edge N when previously empty.
  - No combinational in->out bypass.
  - Pop on out_valid && out_ready.
  - Empty: out_valid=0, out_data/out_flags=0.
  - Full (count==DEPTH): in_ready=0. A pop in the full cycle does not enable a same-cycle push; in_ready rises the cycle after.
  - Simultaneous push and pop when not full and not empty: count unchanged, order preserved.
  - Pop when empty: ignored.
- No overflow or underflow is possible by construction; assertions check count <= DEPTH.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR (2-bit), shared with the ALU and decoder.
  - Flag bit indices FLAG_C=2, FLAG_Z=1, FLAG_N=0.
  - Default DATA_W.
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count) holds the buffer.
- alu_writeback keeps flag logic, the accumulator and the handshake glue.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1 -> acc=0, flags=000, out_valid=0, count=0; no entry accepted.
- Add carry: op=00, result=9'h100, acc_we=1 -> next cycle acc=00, c=1 z=1 n=0; out_data=00, out_flags=3'b110.
- Sub borrow: op=01, result=9'h1FF (3-4), acc_we=1 -> acc=FF, flags c=1 z=0 n=1. Then op=10, result=9'h080, acc_we=0 -> acc stays FF, FIFO head flags 3'b001 after first pop.
- Fill: out_ready=0, push 4 results 01..04 -> count=4, in_ready=0; 5th (05) with in_valid=1 is not accepted. Then out_ready=1 -> pops 01,02,03,04 in order; in_ready rises the cycle after the first pop.
- Concurrent push/pop: steady in_valid=1, out_ready=1 stream of 10 values -> count stays 1, outputs in order, pointer wrap exercised with no drops.
- acc_clr with accept: acc_clr=1, op=00, result=9'h005, acc_we=1 -> acc=0, flags=000; FIFO still receives 05 with flags 3'b000.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Opcode encodings, flag bit positions and the default
//                datapath width shared by the ALU, decoder and result stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // ALU opcodes; add/sub are the only ones that produce a meaningful carry
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // Bit positions inside a packed {c,z,n} flag vector
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;
  localparam int FLAG_W = 3;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/alu_writeback_if.sv
`default_nettype none
// ============================================================================
//  Interface   : alu_writeback_if
//  Description : ALU-result input stream and consumer output stream of the
//                result stage. The stage itself uses the slave modport; the
//                ALU/consumer side uses the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_writeback_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  // Upstream (ALU -> stage)
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W:0]   in_result;
  logic              in_acc_we;

  // Downstream (stage -> consumer)
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, in_op, in_result, in_acc_we, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_result, in_acc_we, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface : alu_writeback_if
`default_nettype wire

// File: rtl/alu_writeback_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with circular read/write pointers and an
//                occupancy counter. Head data reads as zero while empty.
//                Push while full and pop while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [WIDTH-1:0]         wdata,
  output logic      [WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int                 c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]      c_FULL    = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]      c_CNT_ONE = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]    c_PTR_ONE = (c_AW)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == c_FULL);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, head is masked when empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Occupancy can never exceed the number of entries
  always_ff @(posedge clk) begin
    if (rst_n) assert (r_count <= c_FULL);
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback
//  Description : Result stage after the ALU. Derives c/z/n flags from each
//                accepted result, optionally commits it to the accumulator,
//                and queues {result, flags} toward the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  alu_writeback_if.slave               bus,
  input  wire logic                    acc_clr,
  output logic      [DATA_W-1:0]       acc,
  output logic                         flag_c,
  output logic                         flag_z,
  output logic                         flag_n,
  output logic      [$clog2(DEPTH):0]  count
);

  localparam int c_ENTRY_W = DATA_W + FLAG_W;

  logic [DATA_W-1:0]    r_acc;
  logic [FLAG_W-1:0]    r_flags;
  logic [FLAG_W-1:0]    w_flags;
  logic [c_ENTRY_W-1:0] w_wdata;
  logic [c_ENTRY_W-1:0] w_rdata;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  // Flags come straight from the incoming result; only add/sub own a carry
  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_C] = ((bus.in_op == OP_ADD) || (bus.in_op == OP_SUB))
                      ? bus.in_result[DATA_W] : 1'b0;
    w_flags[FLAG_Z] = (bus.in_result[DATA_W-1:0] == '0);
    w_flags[FLAG_N] = bus.in_result[DATA_W-1];
  end

  // Handshake glue: a pop in the full cycle does not open the input that cycle
  assign bus.in_ready  = !w_full;
  assign w_push        = bus.in_valid && !w_full;
  assign bus.out_valid = !w_empty;
  assign w_pop         = !w_empty && bus.out_ready;
  assign w_wdata       = {bus.in_result[DATA_W-1:0], w_flags};

  // Accumulator and sticky flags; clear wins over a same-cycle commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_flags <= '0;
    end else if (acc_clr) begin
      r_acc   <= '0;
      r_flags <= '0;
    end else if (w_push && bus.in_acc_we) begin
      r_acc   <= bus.in_result[DATA_W-1:0];
      r_flags <= w_flags;
    end
  end

  sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  assign bus.out_data  = w_rdata[c_ENTRY_W-1:FLAG_W];
  assign bus.out_flags = w_rdata[FLAG_W-1:0];
  assign acc           = r_acc;
  assign flag_c        = r_flags[FLAG_C];
  assign flag_z        = r_flags[FLAG_Z];
  assign flag_n        = r_flags[FLAG_N];

endmodule : alu_writeback
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_writeback
//  Description : Directed self-checking bench for alu_writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_writeback;

  logic       clk;
  logic       rst_n;
  logic       acc_clr;
  logic [7:0] acc;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic [2:0] count;

  int passed;
  int total;

  alu_writeback_if #(.DATA_W(8)) bus ();

  alu_writeback #(.DATA_W(8), .DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .acc_clr (acc_clr),
    .acc     (acc),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .flag_n  (flag_n),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [8:0] res, input logic we);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_result = res;
    bus.in_acc_we = we;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst_n   = 1'b0;
    acc_clr = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 9'h055, 1'b1);

    // Reset held two cycles with a valid result presented
    tick();
    tick();
    check("rst_acc",       acc, 8'h00);
    check("rst_flags",     {flag_c, flag_z, flag_n}, 3'b000);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_count",     count, 3'd0);
    check("rst_out_data",  bus.out_data, 8'h00);
    check("rst_out_flags", bus.out_flags, 3'b000);
    drive(1'b0, 2'b00, 9'h000, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  bus.in_ready, 1'b1);

    // Add with carry out, zero low byte
    drive(1'b1, 2'b00, 9'h100, 1'b1);
    tick();
    drive(1'b0, 2'b00, 9'h000, 1'b0);
    check("add_acc",       acc, 8'h00);
    check("add_flags",     {flag_c, flag_z, flag_n}, 3'b110);
    check("add_out_valid", bus.out_valid, 1'b1);
    check("add_out_data",  bus.out_data, 8'h00);
    check("add_out_flags", bus.out_flags, 3'b110);
    check("add_count",     count, 3'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("add_pop_count", count, 3'd0);
    check("add_pop_valid", bus.out_valid, 1'b0);

    // Subtract with borrow, then AND result not committed
    drive(1'b1, 2'b01, 9'h1FF, 1'b1);
    tick();
    drive(1'b1, 2'b10, 9'h080, 1'b0);
    tick();
    drive(1'b0, 2'b00, 9'h000, 1'b0);
    check("sub_acc",       acc, 8'hFF);
    check("sub_flags",     {flag_c, flag_z, flag_n}, 3'b101);
    check("sub_count",     count, 3'd2);
    check("sub_head_data", bus.out_data, 8'hFF);
    check("sub_head_flags", bus.out_flags, 3'b101);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("and_head_data", bus.out_data, 8'h80);
    check("and_head_flags", bus.out_flags, 3'b001);
    check("and_acc_hold",  acc, 8'hFF);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("and_drained",   count, 3'd0);

    // Fill to capacity, then a fifth result must be held off
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'b00, 9'(i), 1'b0);
      tick();
    end
    check("fill_count",    count, 3'd4);
    check("fill_in_ready", bus.in_ready, 1'b0);
    drive(1'b1, 2'b00, 9'h005, 1'b0);
    tick();
    check("full_block_count", count, 3'd4);
    check("full_head",     bus.out_data, 8'h01);
    drive(1'b0, 2'b00, 9'h000, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("full_pop1_ready", bus.in_ready, 1'b1);
    check("full_pop1_count", count, 3'd3);
    check("full_pop1_head",  bus.out_data, 8'h02);
    tick();
    check("full_pop2_head",  bus.out_data, 8'h03);
    tick();
    check("full_pop3_head",  bus.out_data, 8'h04);
    tick();
    check("full_empty_valid", bus.out_valid, 1'b0);
    check("full_empty_data",  bus.out_data, 8'h00);

    // Streaming with simultaneous push and pop; head trails input by one
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'b11, 9'(8'h10 + i), 1'b0);
      tick();
      check("stream_count", count, 3'd1);
      check("stream_head",  bus.out_data, 32'(8'h10 + i));
    end
    drive(1'b0, 2'b00, 9'h000, 1'b0);
    tick();
    check("stream_drained", count, 3'd0);
    check("stream_acc_hold", acc, 8'hFF);
    bus.out_ready = 1'b0;

    // Clear has priority over a committing accept; FIFO still gets the entry
    acc_clr = 1'b1;
    drive(1'b1, 2'b00, 9'h005, 1'b1);
    tick();
    acc_clr = 1'b0;
    drive(1'b0, 2'b00, 9'h000, 1'b0);
    check("clr_acc",       acc, 8'h00);
    check("clr_flags",     {flag_c, flag_z, flag_n}, 3'b000);
    check("clr_out_data",  bus.out_data, 8'h05);
    check("clr_out_flags", bus.out_flags, 3'b000);

    // OR opcode masks the carry bit even when set
    drive(1'b1, 2'b11, 9'h100, 1'b1);
    tick();
    drive(1'b0, 2'b00, 9'h000, 1'b0);
    check("or_flags",      {flag_c, flag_z, flag_n}, 3'b010);
    check("or_count",      count, 3'd2);

    // Reset mid-stream discards buffered entries
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_count",  count, 3'd0);
    check("midrst_valid",  bus.out_valid, 1'b0);
    check("midrst_acc",    acc, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_alu_writeback
`default_nettype wire
